// File: rtl/rice_bitstream_packer_pkg.sv
// Shared constants, state encoding and small helpers for the Rice bitstream packer.
package rice_bitstream_packer_pkg;

  localparam int encodedpixel_width  = 32;
  localparam int encodedlength_width = 6;
  localparam int ACC_W               = 2 * encodedpixel_width;
  localparam int bytecount_width     = 32;
  // Fill counter must hold 0..ACC_W inclusive.
  localparam int FILL_W              = $clog2(ACC_W + 1);

  localparam logic [7:0] STUFF_MARKER = 8'hFF;

  typedef enum logic [1:0] {
    PK_RUN   = 2'd0,
    PK_FLUSH = 2'd1,
    PK_PAD   = 2'd2,
    PK_DONE  = 2'd3
  } pk_state_t;

  // Payload bits carried by the next byte: a byte after 0xFF gives its MSB to the stuffed 0.
  function automatic logic [3:0] byte_need(input logic last_ff);
    return last_ff ? 4'd7 : 4'd8;
  endfunction

endpackage

// File: rtl/rice_bitstream_packer_if.sv
// Codeword input and byte output handshake bundle of the Rice bitstream packer.
//
// Handshakes: a codeword moves when in_valid && in_ready at a rising clk edge;
// a byte moves when byte_valid && byte_ready at a rising clk edge. While
// byte_valid is high and byte_ready low, byte_out is held unchanged.
interface rice_bitstream_packer_if;
  import rice_bitstream_packer_pkg::*;

  logic                           in_valid;
  logic                           in_ready;
  logic [encodedpixel_width-1:0]  encoded_pixel;
  logic [encodedlength_width-1:0] encoded_length;
  logic                           flush;
  logic [7:0]                     byte_out;
  logic                           byte_valid;
  logic                           byte_ready;
  logic                           flush_done;
  logic [bytecount_width-1:0]     byte_count;

  modport master (
    output in_valid, encoded_pixel, encoded_length, flush, byte_ready,
    input  in_ready, byte_out, byte_valid, flush_done, byte_count
  );

  modport slave (
    input  in_valid, encoded_pixel, encoded_length, flush, byte_ready,
    output in_ready, byte_out, byte_valid, flush_done, byte_count
  );

endinterface

// File: rtl/rice_bit_accumulator.sv
// MSB-aligned bit accumulator: bits occupy acc[ACC_W-1 -: fill].
// Each cycle, remove_len bits leave from the top, then append_len new bits
// are placed directly below whatever remains. Bits below fill are always zero,
// so a partially filled top byte reads as zero-padded.
module rice_bit_accumulator
  import rice_bitstream_packer_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           append_en,
  input  logic [encodedpixel_width-1:0]  append_bits,
  input  logic [encodedlength_width-1:0] append_len,
  input  logic [3:0]                     remove_len,
  output logic [ACC_W-1:0]               acc,
  output logic [FILL_W-1:0]              fill,
  output logic [ACC_W-1:0]               acc_next,
  output logic [FILL_W-1:0]              fill_next
);

  logic [FILL_W-1:0]              fill_after;
  logic [encodedlength_width-1:0] len_eff;
  logic [ACC_W-1:0]               one_w;
  logic [ACC_W-1:0]               mask;
  logic [ACC_W-1:0]               bits_w;
  logic [7:0]                     shift;

  // Remove consumed bits from the top, then merge the masked codeword below the survivors.
  always_comb begin
    one_w      = {{(ACC_W-1){1'b0}}, 1'b1};
    fill_after = fill - FILL_W'(remove_len);
    len_eff    = append_en ? append_len : '0;
    mask       = (one_w << len_eff) - one_w;
    bits_w     = {{(ACC_W-encodedpixel_width){1'b0}}, append_bits} & mask;
    shift      = 8'(ACC_W) - {1'b0, fill_after} - {2'b00, len_eff};
    acc_next   = (acc << remove_len) | (append_en ? (bits_w << shift) : '0);
    fill_next  = fill_after + FILL_W'(len_eff);
  end

  // Accumulator and fill register; reset drops every buffered bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_next;
      fill <= fill_next;
    end
  end

endmodule

// File: rtl/rice_bitstream_packer.sv
// Packs right-justified Rice codewords MSB-first into a JPEG-LS byte stream
// with 0xFF bit stuffing, zero padding on flush and registered byte output.
module rice_bitstream_packer
  import rice_bitstream_packer_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  rice_bitstream_packer_if.slave   pk,
  output pk_state_t                dbg_state,
  output logic [FILL_W-1:0]        dbg_fill
);

  pk_state_t                  state;
  pk_state_t                  state_next;
  logic                       last_ff;
  logic                       last_ff_next;
  logic [ACC_W-1:0]           acc;
  logic [ACC_W-1:0]           acc_next;
  logic [FILL_W-1:0]          fill;
  logic [FILL_W-1:0]          fill_next;
  logic [3:0]                 take;
  logic [3:0]                 take_next;
  logic [3:0]                 remove_len;
  logic [3:0]                 need_next;
  logic                       byte_valid_r;
  logic                       valid_next;
  logic [7:0]                 byte_out_r;
  logic [7:0]                 out_next;
  logic [7:0]                 top_byte;
  logic [bytecount_width-1:0] count;
  logic                       ready_int;
  logic                       accept;
  logic                       xfer;

  // Room for one worst-case codeword; closed outside RUN and while reset is asserted.
  assign ready_int  = reset && (state == PK_RUN) &&
                      (fill <= FILL_W'(ACC_W - encodedpixel_width));
  assign accept     = pk.in_valid && ready_int;
  assign xfer       = byte_valid_r && pk.byte_ready;
  // `take` is the number of accumulator bits the presented byte stands for (0 for the PAD byte).
  assign remove_len = xfer ? take : 4'd0;

  rice_bit_accumulator u_acc (
    .clk         (clk),
    .reset       (reset),
    .append_en   (accept),
    .append_bits (pk.encoded_pixel),
    .append_len  (pk.encoded_length),
    .remove_len  (remove_len),
    .acc         (acc),
    .fill        (fill),
    .acc_next    (acc_next),
    .fill_next   (fill_next)
  );

  // Next-state logic and stuffing flag tracking.
  always_comb begin
    state_next   = state;
    last_ff_next = last_ff;
    if (xfer) last_ff_next = (byte_out_r == STUFF_MARKER);
    unique case (state)
      PK_RUN: begin
        if (pk.flush) begin
          // Nothing buffered, nothing pending and nothing arriving: finish immediately.
          if ((fill == '0) && !byte_valid_r && !(accept && (pk.encoded_length != '0)))
            state_next = last_ff ? PK_PAD : PK_DONE;
          else
            state_next = PK_FLUSH;
        end
      end
      PK_FLUSH: begin
        if ((fill == '0) && !byte_valid_r)
          state_next = last_ff ? PK_PAD : PK_DONE;
      end
      PK_PAD: begin
        if (xfer) state_next = PK_DONE;
      end
      PK_DONE: begin
        state_next   = PK_RUN;
        last_ff_next = 1'b0;
      end
      default: state_next = PK_RUN;
    endcase
  end

  // Choose the byte to present next cycle: hold while stalled, else full, padded or PAD byte.
  always_comb begin
    need_next  = byte_need(last_ff_next);
    top_byte   = last_ff_next ? {1'b0, acc_next[ACC_W-1 -: 7]} : acc_next[ACC_W-1 -: 8];
    valid_next = byte_valid_r;
    out_next   = byte_out_r;
    take_next  = take;
    if (!byte_valid_r || pk.byte_ready) begin
      valid_next = 1'b0;
      if (state_next == PK_PAD) begin
        valid_next = 1'b1;
        out_next   = 8'h00;
        take_next  = 4'd0;
      end else if (state_next != PK_DONE) begin
        if (fill_next >= FILL_W'(need_next)) begin
          valid_next = 1'b1;
          out_next   = top_byte;
          take_next  = need_next;
        end else if ((state_next == PK_FLUSH) && (fill_next != '0)) begin
          valid_next = 1'b1;
          out_next   = top_byte;
          take_next  = fill_next[3:0];
        end
      end
    end
  end

  // State, stuffing flag, output byte register and byte counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= PK_RUN;
      last_ff      <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_out_r   <= 8'h00;
      take         <= 4'd0;
      count        <= '0;
    end else begin
      state        <= state_next;
      last_ff      <= last_ff_next;
      byte_valid_r <= valid_next;
      byte_out_r   <= out_next;
      take         <= take_next;
      if (xfer) count <= count + 1'b1;
    end
  end

  // Codewords longer than the pixel field are illegal.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      assert (pk.encoded_length <= encodedlength_width'(encodedpixel_width));
    end
  end

  assign pk.in_ready   = ready_int;
  assign pk.byte_out   = byte_out_r;
  assign pk.byte_valid = byte_valid_r;
  assign pk.flush_done = (state == PK_DONE);
  assign pk.byte_count = count;
  assign dbg_state     = state;
  assign dbg_fill      = fill;

endmodule
